// File: rtl/con_ctrl.sv
// Sequencing controller for the 49-tap convolution pipeline: window issue, tag tracking, result FIFO.
// Optional build macro CON_CTRL_RELU_EN clamps negative results to zero on FIFO write.
module con_ctrl #(
    parameter int OUT_W = 39,
    parameter int LAT   = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_win,
    output logic                    busy,
    output logic                    done,
    output logic                    win_req,
    input  logic                    win_ack,
    output logic [CNT_W-1:0]        win_idx,
    input  logic signed [OUT_W-1:0] con_res,
    output logic signed [OUT_W-1:0] res_data,
    output logic                    res_vld,
    input  logic                    res_rdy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int INF_W  = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_win_q, n_win_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [LAT-1:0]      tag_q, tag_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic signed [OUT_W-1:0] mem_q [DEPTH];

    logic issue, push, pop, credit_ok;

    function automatic logic signed [OUT_W-1:0] store_val(input logic signed [OUT_W-1:0] v);
`ifdef CON_CTRL_RELU_EN
        return v[OUT_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Every issued window will land in the FIFO, so in-flight tags count against its free slots.
    assign credit_ok = (int'(inflight_q) + int'(fifo_cnt_q)) < DEPTH;
    assign win_req   = (state_q == RUN) && (idx_q < n_win_q) && credit_ok;
    assign issue     = win_req && win_ack;
    assign push      = tag_q[LAT-1];
    assign res_vld   = (fifo_cnt_q != '0);
    assign pop       = res_vld && res_rdy;
    assign res_data  = res_vld ? mem_q[rd_ptr_q] : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign win_idx   = idx_q;

    always_comb begin
        state_d    = state_q;
        n_win_d    = n_win_q;
        idx_d      = issue ? idx_q + CNT_W'(1) : idx_q;
        done_d     = 1'b0;
        tag_d      = {tag_q[LAT-2:0], issue};
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_win != '0) begin
                        n_win_d = n_win;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue && (idx_d == n_win_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight_d == '0) && (fifo_cnt_d == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_win_q    <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_win_q    <= n_win_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Result storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= store_val(con_res);
    end

endmodule
